mem_delayed: RTL and testbench
==============================

Name: mem_delayed

Overview:
- Parametrised single-port memory behind a request/acknowledge bus with programmable access latency; successor to the fixed 8-bit, single-cycle-read test memory.
- Serves one bus master (core or cache) and models DRAM-like delay.
- Keeps a separate out-of-band (oob) write port for preloading program/data before the master leaves reset.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 8, address bits (word addressed)
DEPTH, 256, number of words; DEPTH <= 2**ADDR_WIDTH
LATENCY, 4, clock edges from request acceptance to ack; legal range 1..15

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
rd_req  input  1  read request, sampled when busy=0
wr_req  input  1  write request, sampled when busy=0
addr  input  ADDR_WIDTH  request word address
wr_data  input  DATA_WIDTH  write data
busy  output  1  request in flight or oob write active; new requests ignored
ack  output  1  one-cycle completion pulse
rd_data  output  DATA_WIDTH  read result, valid from ack cycle onward
oob_wen  input  1  preload write enable
oob_addr  input  ADDR_WIDTH  preload address
oob_wr_data  input  DATA_WIDTH  preload data

Behaviour:
- Reset: posedge clk with rst_n=0 gives:
  - state=IDLE, busy=0, ack=0, rd_data=0, latency counter=0.
  - Memory array is not cleared.
- OOB port:
  - oob_wen=1 writes oob_wr_data to mem[oob_addr] at the posedge, including while rst_n=0.
  - busy is forced to 1 combinationally while oob_wen=1.
  - No bus request is accepted in that cycle.
- States:
  - IDLE: if busy=0 and (rd_req|wr_req), accept: latch addr, wr_data and op; busy<=1; cnt<=LATENCY-1; go to WAIT.
  - Accept with both rd_req and wr_req high: write only, rd_data unchanged.
  - WAIT, cnt!=0: cnt<=cnt-1.
  - WAIT, cnt==0: perform op on latched values; ack<=1; busy<=0; go to IDLE.
- Timing:
  - Accept at edge E0 gives ack high after edge E0+LATENCY, for exactly one cycle.
  - Write commits at that same edge.
  - rd_data updates at that same edge and holds until the next read completes.
- Back-to-back:
  - busy=0 during the ack cycle, so a request present then is accepted at the next edge.
  - Peak throughput is one access per LATENCY+1 cycles.
  - Master must drop its request in the ack cycle or it is treated as a new request.
- Requests asserted while busy=1 are ignored and not queued. Inputs changing during WAIT have no effect (latched copies are used).
- Out of range (latched addr >= DEPTH):
  - Read returns 0.
  - Write is dropped.
  - ack is still pulsed.
- OOB write and bus write completing on the same edge to the same address: bus write wins.
- Reset mid-operation (rst_n=0 during WAIT):
  - Access aborted; no write commit; no ack.
  - rd_data=0.
  - Returns to IDLE.
- Widths:
  - cnt is 4 bits.
  - Address compare is unsigned, at full ADDR_WIDTH.

Optional Feature:
- Macro: MEM_DELAYED_WMASK_EN.
- Defined:
  - Adds input wr_mask, width DATA_WIDTH/8; DATA_WIDTH must be a multiple of 8.
  - Latched at acceptance.
  - At write commit, only bytes with mask bit 1 are updated; mask 0 leaves the word unchanged but ack is still pulsed.
  - OOB writes are always full-word.
- Undefined:
  - No wr_mask port.
  - All writes are full-word.

Test Plan:
- Preload under reset:
  - Stimulus: rst_n=0, oob writes mem[i]=i+3 for i=0..7; release reset; read addr 5 with LATENCY=4.
  - Required: busy=1 for 4 cycles; ack after 4th edge; rd_data=8.
- Write then read:
  - Stimulus: wr addr 0x10 data 0xDEADBEEF; after ack, rd addr 0x10.
  - Required: second ack with rd_data=0xDEADBEEF; exactly 2 ack pulses.
- Back-to-back and ignored requests:
  - Stimulus: rd_req held high continuously on addr 2; rd_req pulsed while busy=1.
  - Required: acks every LATENCY+1=5 cycles; mid-WAIT pulses produce no extra ack.
- Boundaries:
  - Stimulus: DEPTH=200, read addr 250; simultaneous rd_req+wr_req to addr 3 data 0x55.
  - Required: first read returns 0 with ack; second op writes mem[3]=0x55, rd_data unchanged.
- Reset mid-operation:
  - Stimulus: wr addr 7 data 0x1234; rst_n=0 two cycles after acceptance; then read addr 7.
  - Required: no ack during reset; rd_data=0; read returns original mem[7].
- Mask (MEM_DELAYED_WMASK_EN defined):
  - Stimulus: mem[1]=0x11223344; write 0xAABBCCDD with wr_mask=4'b0101.
  - Required: read returns 0x11BB33DD.

Source files
------------

// File: rtl/mem_delayed.sv
// ============================================================================
// mem_delayed : single-port memory behind a req/ack bus with programmable
//               latency and an out-of-band preload port.
//               Optional byte mask: define MEM_DELAYED_WMASK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_delayed #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef MEM_DELAYED_WMASK_EN
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
`endif
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  oob_wen,
  input  logic [ADDR_WIDTH-1:0] oob_addr,
  input  logic [DATA_WIDTH-1:0] oob_wr_data
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]          c_cnt_init = 4'(LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                r_state;
  logic                  r_busy;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_wr;

  logic                  w_in_range;
  logic                  w_oob_in_range;
  logic                  w_complete;
  logic [DATA_WIDTH-1:0] w_wr_word;

  assign busy           = r_busy | oob_wen;
  assign w_in_range     = ({1'b0, r_addr} < c_depth);
  assign w_oob_in_range = ({1'b0, oob_addr} < c_depth);
  assign w_complete     = (r_state == ST_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_DELAYED_WMASK_EN
  logic [DATA_WIDTH/8-1:0] r_mask;
  logic [DATA_WIDTH-1:0]   w_old_word;

  assign w_old_word = mem[r_addr];

  always_comb begin
    w_wr_word = w_old_word;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (r_mask[b]) begin
        w_wr_word[b*8 +: 8] = r_wdata[b*8 +: 8];
      end
    end
  end
`else
  assign w_wr_word = r_wdata;
`endif

  // Bus write is placed after the preload write so it wins on a collision.
  always_ff @(posedge clk) begin
    if (oob_wen && w_oob_in_range) begin
      mem[oob_addr] <= oob_wr_data;
    end
    if (rst_n && w_complete && r_is_wr && w_in_range) begin
      mem[r_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      ack     <= 1'b0;
      rd_data <= '0;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
`ifdef MEM_DELAYED_WMASK_EN
      r_mask  <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!busy && (rd_req || wr_req)) begin
            r_addr  <= addr;
            r_wdata <= wr_data;
            r_is_wr <= wr_req;
`ifdef MEM_DELAYED_WMASK_EN
            r_mask  <= wr_mask;
`endif
            r_busy  <= 1'b1;
            r_cnt   <= c_cnt_init;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_is_wr) begin
              rd_data <= w_in_range ? mem[r_addr] : '0;
            end
            ack     <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_delayed.sv
// ============================================================================
// tb_mem_delayed : directed, table-driven bench for mem_delayed (DEPTH=200).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_delayed;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 200;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, wr_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_mask;
  logic          busy, ack;
  logic [DW-1:0] rd_data;
  logic          oob_wen;
  logic [AW-1:0] oob_addr;
  logic [DW-1:0] oob_wr_data;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  mem_delayed #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_data(wr_data),
`ifdef MEM_DELAYED_WMASK_EN
    .wr_mask(wr_mask),
`endif
    .busy(busy), .ack(ack), .rd_data(rd_data),
    .oob_wen(oob_wen), .oob_addr(oob_addr), .oob_wr_data(oob_wr_data)
  );

  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a posedge+1 sample point; returns edges to ack
  // and number of post-accept samples with busy high. Ends in the ack cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] m,
                       output int lat, output int bc);
    rd_req = rd; wr_req = wr; addr = a; wr_data = d; wr_mask = m;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    chk("ack_low_after_accept", {31'd0, ack}, 32'd0);
    lat = 0; bc = 0;
    while (!ack && lat < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_low_in_ack_cycle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, bc, snap;
    logic [14:0] pattern;

    rst_n = 1'b0; rd_req = 0; wr_req = 0; addr = '0; wr_data = '0; wr_mask = 4'hF;
    oob_wen = 0; oob_addr = '0; oob_wr_data = '0;
    @(posedge clk); #1;

    // Preload under reset
    for (int i = 0; i < 8; i++) begin
      oob_wen = 1'b1; oob_addr = AW'(i); oob_wr_data = DW'(i + 3);
      #1;
      if (i == 0) chk("busy_forced_by_oob", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    oob_wen = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    do_op(1'b1, 1'b0, 8'd5, 32'd0, 4'hF, lat, bc);
    chk("preload_lat", lat, LAT);
    chk("preload_busy_cycles", bc, LAT);
    chk("preload_rd5", rd_data, 32'd8);

    vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'd8};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 8'd250, 32'h0,       32'h0};
    vecs[3] = '{1'b1, 1'b0, 8'd3,  32'h0,        32'd6};
    vecs[4] = '{1'b1, 1'b1, 8'd3,  32'h55,       32'd6};
    vecs[5] = '{1'b1, 1'b0, 8'd3,  32'h0,        32'h55};
    vecs[6] = '{1'b0, 1'b1, 8'd250, 32'hFFFF,    32'h55};
    vecs[7] = '{1'b0, 1'b1, 8'd199, 32'hCAFEF00D, 32'h55};
    vecs[8] = '{1'b1, 1'b0, 8'd199, 32'h0,       32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b0, 8'd200, 32'h0,       32'h0};

    snap = ack_cnt;
    for (int v = 0; v < 10; v++) begin
      do_op(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, 4'hF, lat, bc);
      chk($sformatf("vec%0d_lat", v), lat, LAT);
      chk($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].exp_rd);
      if (v == 1) begin
        @(negedge clk);
        chk("wr_rd_ack_pulses", ack_cnt - snap, 32'd2);
        @(posedge clk); #1;
      end
    end

    // Back-to-back: request held high
    rd_req = 1'b1; addr = 8'd2;
    pattern = '0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      pattern[k-1] = ack;
      if (ack) chk("b2b_rd_data", rd_data, 32'd5);
    end
    rd_req = 1'b0;
    chk("b2b_ack_pattern", {17'd0, pattern}, {17'd0, 15'b100001000010000});
    @(posedge clk); #1;

    // Requests pulsed while busy are ignored
    rd_req = 1'b1; addr = 8'd4;
    @(posedge clk); #1;
    rd_req = 1'b0;
    snap = ack_cnt;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 2) begin
        wr_req = 1'b1; rd_req = 1'b1; addr = 8'd4; wr_data = 32'h999;
      end else begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ignored_req_acks", ack_cnt - snap, 32'd1);
    chk("ignored_req_rd_data", rd_data, 32'd7);
    @(posedge clk); #1;

    // Reset mid-operation
    wr_req = 1'b1; addr = 8'd7; wr_data = 32'h1234;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    snap = ack_cnt;
    @(posedge clk); #1;
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_ack", ack_cnt - snap, 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 8'd7, 32'd0, 4'hF, lat, bc);
    chk("midrst_rd7", rd_data, 32'd10);

    // OOB write blocks acceptance in its cycle
    oob_wen = 1'b1; oob_addr = 8'd20; oob_wr_data = 32'h2020; rd_req = 1'b1; addr = 8'd20;
    @(posedge clk); #1;
    oob_wen = 1'b0; rd_req = 1'b0;
    #1;
    chk("oob_blocks_accept", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Bus write and OOB write on the same edge: bus wins
    wr_req = 1'b1; addr = 8'd30; wr_data = 32'hAAAA0001;
    @(posedge clk); #1;
    wr_req = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      @(posedge clk); #1;
    end
    oob_wen = 1'b1; oob_addr = 8'd30; oob_wr_data = 32'hBBBB0002;
    @(posedge clk); #1;
    oob_wen = 1'b0;
    chk("collision_ack", {31'd0, ack}, 32'd1);
    do_op(1'b1, 1'b0, 8'd30, 32'd0, 4'hF, lat, bc);
    chk("collision_bus_wins", rd_data, 32'hAAAA0001);
    do_op(1'b1, 1'b0, 8'd20, 32'd0, 4'hF, lat, bc);
    chk("oob_rd20", rd_data, 32'h2020);

`ifdef MEM_DELAYED_WMASK_EN
    oob_wen = 1'b1; oob_addr = 8'd1; oob_wr_data = 32'h11223344;
    @(posedge clk); #1;
    oob_wen = 1'b0;
    do_op(1'b0, 1'b1, 8'd1, 32'hAABBCCDD, 4'b0101, lat, bc);
    chk("mask_wr_lat", lat, LAT);
    do_op(1'b1, 1'b0, 8'd1, 32'd0, 4'hF, lat, bc);
    chk("mask_0101", rd_data, 32'h11BB33DD);
    do_op(1'b0, 1'b1, 8'd1, 32'hFFFFFFFF, 4'b0000, lat, bc);
    chk("mask_zero_ack_lat", lat, LAT);
    do_op(1'b1, 1'b0, 8'd1, 32'd0, 4'hF, lat, bc);
    chk("mask_0000", rd_data, 32'h11BB33DD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
